// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, controller state and opcode-class encodings shared across the CPU
package cpu_pkg;
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_LW  = 6'b010000;
    localparam logic [5:0] OP_SW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_ILL
    } cls_t;
endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: maps the 6-bit opcode to its execution class
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    output cls_t       cls
);
    always_comb begin
        cls = (op <= OP_SLT)                 ? CLS_ALU :
              (op == OP_LW)                  ? CLS_LD  :
              (op == OP_SW)                  ? CLS_ST  :
              (op == OP_BEQ || op == OP_JMP) ? CLS_BR  : CLS_ILL;
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer with retire counter and sticky halt
module mc_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic             cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             npc_we,
    output logic             ab_we,
    output logic             alu_we,
    output logic             lmd_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             reg_src,
    output logic             busy,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);
    state_t state, nxt;
    cls_t   cls;

    op_class_decode u_dec (.op(op), .cls(cls));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? S_IF : S_IDLE;
            S_IF:    nxt = mem_ready ? S_ID : S_IF;
            S_ID:    nxt = (cls == CLS_ILL) ? S_HALT : S_EX;
            S_EX:    nxt = (cls == CLS_ALU) ? S_WB :
                           (cls == CLS_LD || cls == CLS_ST) ? S_MEM :
                           (cls == CLS_BR) ? S_IF : S_HALT;
            S_MEM:   nxt = !mem_ready ? S_MEM : (cls == CLS_LD) ? S_WB : S_IF;
            S_WB:    nxt = S_IF;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    // Every output is decoded from the current state, so async reset clears them at once
    always_comb begin
        mem_req = (state == S_IF) || (state == S_MEM);
        mem_sel = (state == S_MEM);
        mem_we  = (state == S_MEM) && (cls == CLS_ST);
        ir_we   = (state == S_IF) && mem_ready;
        npc_we  = ir_we;
        ab_we   = (state == S_ID);
        alu_we  = (state == S_EX);
        lmd_we  = (state == S_MEM) && mem_ready && (cls == CLS_LD);
        pc_we   = ((state == S_EX) && (cls == CLS_BR)) ||
                  ((state == S_MEM) && mem_ready && (cls == CLS_ST)) ||
                  (state == S_WB);
        pc_sel  = (state == S_EX) && (cls == CLS_BR) && cond;
        reg_we  = (state == S_WB);
        reg_src = (state == S_WB) && (cls == CLS_LD);
        busy    = (state != S_IDLE) && (state != S_HALT);
        halt    = (state == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     retired <= '0;
        else if (pc_we) retired <= retired + CNT_W'(1);
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of mc_ctrl sequencing, waits, halt, async reset and counter wrap
module tb_mc_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [5:0]  op = 0;
    logic        cond = 0;
    logic        mem_ready = 0;
    logic        mem_req, mem_we, mem_sel, ir_we, npc_we, ab_we, alu_we, lmd_we;
    logic        pc_we, pc_sel, reg_we, reg_src, busy, halt;
    logic [31:0] retired;
    logic [13:0] o4;
    logic [3:0]  retired4;
    logic [13:0] sig;
    int          total = 0;
    int          bad = 0;

    // bit order: req we sel ir npc ab alu lmd pc_we pc_sel reg_we reg_src busy halt
    localparam logic [13:0] E_IDLE   = 14'b00000000000000;
    localparam logic [13:0] E_IF_W   = 14'b10000000000010;
    localparam logic [13:0] E_IF_R   = 14'b10011000000010;
    localparam logic [13:0] E_ID     = 14'b00000100000010;
    localparam logic [13:0] E_EX     = 14'b00000010000010;
    localparam logic [13:0] E_EX_B1  = 14'b00000010110010;
    localparam logic [13:0] E_EX_B0  = 14'b00000010100010;
    localparam logic [13:0] E_MLD_W  = 14'b10100000000010;
    localparam logic [13:0] E_MLD_R  = 14'b10100001000010;
    localparam logic [13:0] E_MST_W  = 14'b11100000000010;
    localparam logic [13:0] E_MST_R  = 14'b11100000100010;
    localparam logic [13:0] E_WB_ALU = 14'b00000000101010;
    localparam logic [13:0] E_WB_LD  = 14'b00000000101110;
    localparam logic [13:0] E_HALT   = 14'b00000000000001;

    always #5 clk = ~clk;

    assign sig = {mem_req, mem_we, mem_sel, ir_we, npc_we, ab_we, alu_we, lmd_we,
                  pc_we, pc_sel, reg_we, reg_src, busy, halt};

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cond(cond), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .npc_we(npc_we),
        .ab_we(ab_we), .alu_we(alu_we), .lmd_we(lmd_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .reg_src(reg_src), .busy(busy), .halt(halt), .retired(retired)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cond(cond), .mem_ready(mem_ready),
        .mem_req(o4[13]), .mem_we(o4[12]), .mem_sel(o4[11]), .ir_we(o4[10]), .npc_we(o4[9]),
        .ab_we(o4[8]), .alu_we(o4[7]), .lmd_we(o4[6]), .pc_we(o4[5]), .pc_sel(o4[4]),
        .reg_we(o4[3]), .reg_src(o4[2]), .busy(o4[1]), .halt(o4[0]), .retired(retired4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check the combinational outputs, then advance past the edge
    task automatic st(input string tag, input logic [5:0] o, input logic c, input logic r,
                      input logic s, input logic [13:0] exp);
        op = o; cond = c; mem_ready = r; start = s;
        #1;
        chk(tag, {18'd0, sig}, {18'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; mem_ready = 0; cond = 0;
        #1;
        chk("reset_outs", {18'd0, sig}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        // ADD with zero wait states: IF, ID, EX, WB then straight back to IF
        st("add_idle", 6'b000000, 0, 1, 0, E_IDLE);
        st("add_start", 6'b000000, 0, 1, 1, E_IDLE);
        st("add_if", 6'b000000, 0, 1, 0, E_IF_R);
        st("add_id", 6'b000000, 0, 1, 1, E_ID);
        chk("add_ret0", retired, 32'd0);
        st("add_ex", 6'b000000, 0, 1, 0, E_EX);
        st("add_wb", 6'b000000, 0, 1, 0, E_WB_ALU);
        chk("add_ret1", retired, 32'd1);
        st("add_next_if", 6'b000000, 0, 0, 0, E_IF_W);

        // LOAD with two wait cycles in IF and in MEM: retires at the end of cycle 9
        do_reset();
        st("ld_start", 6'b010000, 0, 0, 1, E_IDLE);
        st("ld_if_w1", 6'b010000, 0, 0, 0, E_IF_W);
        st("ld_if_w2", 6'b010000, 0, 0, 1, E_IF_W);
        st("ld_if_r", 6'b010000, 0, 1, 0, E_IF_R);
        st("ld_id", 6'b010000, 0, 1, 0, E_ID);
        st("ld_ex", 6'b010000, 0, 1, 0, E_EX);
        st("ld_mem_w1", 6'b010000, 0, 0, 0, E_MLD_W);
        st("ld_mem_w2", 6'b010000, 0, 0, 0, E_MLD_W);
        chk("ld_ret0", retired, 32'd0);
        st("ld_mem_r", 6'b010000, 0, 1, 0, E_MLD_R);
        st("ld_wb", 6'b010000, 0, 0, 0, E_WB_LD);
        chk("ld_ret1", retired, 32'd1);

        // STORE, then BEQ taken and not taken back to back
        do_reset();
        st("st_start", 6'b010001, 0, 0, 1, E_IDLE);
        st("st_if", 6'b010001, 0, 1, 0, E_IF_R);
        st("st_id", 6'b010001, 0, 0, 0, E_ID);
        st("st_ex", 6'b010001, 0, 0, 0, E_EX);
        st("st_mem_w", 6'b010001, 0, 0, 0, E_MST_W);
        st("st_mem_r", 6'b010001, 0, 1, 0, E_MST_R);
        chk("st_ret", retired, 32'd1);
        st("beq1_if", 6'b100000, 1, 1, 0, E_IF_R);
        st("beq1_id", 6'b100000, 1, 0, 0, E_ID);
        st("beq1_ex", 6'b100000, 1, 0, 0, E_EX_B1);
        chk("beq1_ret", retired, 32'd2);
        st("beq0_if", 6'b100000, 0, 1, 0, E_IF_R);
        st("beq0_id", 6'b100000, 0, 0, 0, E_ID);
        st("beq0_ex", 6'b100000, 0, 0, 0, E_EX_B0);
        chk("beq0_ret", retired, 32'd3);

        // Illegal opcode halts; start and mem_ready cannot revive it
        do_reset();
        st("ill_start", 6'b111111, 0, 0, 1, E_IDLE);
        st("ill_if", 6'b111111, 0, 1, 0, E_IF_R);
        st("ill_id", 6'b111111, 0, 1, 0, E_ID);
        for (int i = 0; i < 4; i++) st("ill_halt", 6'b000000, 0, i[0], 1, E_HALT);
        chk("ill_ret", retired, 32'd0);

        // Async reset mid-MEM of a STORE after one retired JMP
        do_reset();
        st("rs_start", 6'b100001, 0, 0, 1, E_IDLE);
        st("rs_jif", 6'b100001, 0, 1, 0, E_IF_R);
        st("rs_jid", 6'b100001, 0, 1, 0, E_ID);
        st("rs_jex", 6'b100001, 0, 1, 0, E_EX_B0);
        st("rs_sif", 6'b010001, 0, 1, 0, E_IF_R);
        st("rs_sid", 6'b010001, 0, 0, 0, E_ID);
        st("rs_sex", 6'b010001, 0, 0, 0, E_EX);
        op = 6'b010001; mem_ready = 0;
        #1;
        chk("rs_mem", {18'd0, sig}, {18'd0, E_MST_W});
        chk("rs_ret_pre", retired, 32'd1);
        rst_n = 0;
        #1;
        chk("rs_drop", {18'd0, sig}, 32'd0);
        chk("rs_ret_clr", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        st("rs_restart", 6'b000000, 0, 0, 1, E_IDLE);
        st("rs_refetch", 6'b000000, 0, 1, 0, E_IF_R);

        // 17 JMPs: the 4-bit counter wraps to 1
        do_reset();
        st("jw_start", 6'b100001, 0, 0, 1, E_IDLE);
        for (int i = 0; i < 17; i++) begin
            st("jw_if", 6'b100001, i[0], 1, 0, E_IF_R);
            st("jw_id", 6'b100001, i[0], 0, 0, E_ID);
            st("jw_ex", 6'b100001, i[0], 0, 0, i[0] ? E_EX_B1 : E_EX_B0);
        end
        chk("jw_ret32", retired, 32'd17);
        chk("jw_ret4", {28'd0, retired4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
